module_while_read: RTL

- Consumer end of the loop_if handshake: samples the index/done pair that a loop writer drives on its Ctrl side, and reconstructs the loop's progress over time.
- Tracks the iteration count and last index, detects normal completion, and flags protocol violations.
- Sits beside loop-writer blocks as a checker/reporter feeding status registers.

---
 rtl/module_while_read.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/module_while_read.sv
// Consumer/checker for the loop_if Ctrl-side index/done handshake: tracks loop progress,
// flags completion and protocol errors. Optional RUN idle timeout via LOOP_READ_TIMEOUT_EN.
module module_while_read #(
  parameter int unsigned LIMIT   = 10,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic [IDX_W-1:0] loop_index,
  input  logic             loop_done,
  input  logic             clear_err,
  output logic             busy,
  output logic             complete,
  output logic             done_pulse,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] iter_count,
  output logic [IDX_W-1:0] last_index
);

  if (LIMIT > (1 << IDX_W)) begin : g_bad_limit
    $error("LIMIT must not exceed 2**IDX_W");
  end
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("TIMEOUT must be nonzero");
  end

  localparam logic [IDX_W:0]   LimitExt = (IDX_W + 1)'(LIMIT);
  localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(LIMIT - 1);

  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrStep    = 2'd1;
  localparam logic [1:0] ErrRange   = 2'd2;
  localparam logic [1:0] ErrTimeout = 2'd3;

  typedef enum logic [1:0] {StIdle, StRun, StDone, StErr} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [1:0]       code_q, code_d;
  logic             complete_q, complete_d;

  logic idx_in_range;
  logic idx_is_next;

  assign idx_in_range = {1'b0, loop_index} < LimitExt;
  // Compared one bit wider so all-ones followed by 0 is never treated as a step.
  assign idx_is_next  = {1'b0, loop_index} == ({1'b0, last_q} + (IDX_W + 1)'(1));

`ifdef LOOP_READ_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  logic [TmoW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = '0;
    if (state_q == StRun && !sample_en) begin
      tmo_d = tmo_q + TmoW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      iter_q     <= '0;
      last_q     <= '0;
      code_q     <= ErrNone;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      last_q     <= last_d;
      code_q     <= code_d;
      complete_q <= complete_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    last_d     = last_q;
    code_d     = code_q;
    complete_d = complete_q;
    unique case (state_q)
      StIdle: begin
        // A done report while idle is the writer's disabled status and is ignored.
        if (sample_en && !loop_done) begin
          if (idx_in_range) begin
            state_d    = StRun;
            iter_d     = CNT_W'(1);
            last_d     = loop_index;
            complete_d = 1'b0;
          end else begin
            state_d = StErr;
            code_d  = ErrRange;
          end
        end
      end
      StRun: begin
        if (sample_en) begin
          if (loop_done) begin
            if (last_q == LastIdx) begin
              state_d    = StDone;
              complete_d = 1'b1;
            end else begin
              state_d = StErr;
              code_d  = ErrStep;
            end
          end else if (loop_index == last_q) begin
            state_d = StRun;
          end else if (idx_is_next && idx_in_range) begin
            iter_d = (iter_q == {CNT_W{1'b1}}) ? iter_q : iter_q + CNT_W'(1);
            last_d = loop_index;
          end else begin
            state_d = StErr;
            code_d  = idx_in_range ? ErrStep : ErrRange;
          end
        end
`ifdef LOOP_READ_TIMEOUT_EN
        else if (tmo_q == TmoLast) begin
          state_d = StErr;
          code_d  = ErrTimeout;
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
      end
      StErr: begin
        if (clear_err) begin
          state_d = StIdle;
          code_d  = ErrNone;
          iter_d  = '0;
          last_d  = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy       = (state_q == StRun);
    done_pulse = (state_q == StDone);
    error      = (state_q == StErr);
    complete   = complete_q;
    err_code   = code_q;
    iter_count = iter_q;
    last_index = last_q;
  end

endmodule
